// File: rtl/video_sampler_pkg.sv
// Shared types and helpers for the video frame sampler.
// - rgb888_t    : packed {r,g,b} pixel, 8 bits per channel
// - out_state_t : output streaming FSM states
// - MATRIX_W_DEF / MATRIX_H_DEF : default matrix geometry
// - addr_w(n)   : address width needed to index n entries (minimum 1)
package video_sampler_pkg;

  localparam int MATRIX_W_DEF = 16;
  localparam int MATRIX_H_DEF = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } out_state_t;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sampler_frame_buf.sv
// Two-bank simple dual-port frame buffer.
// The sampler writes the back bank while the output side reads the front
// bank; the bank-select inputs are driven by the top so a swap is a single
// flag toggle, no data copy.
// Ports:
// - clk        : clock
// - i_wr_en    : write strobe
// - i_wr_bank  : bank written
// - i_wr_addr  : entry index inside the bank
// - i_wr_data  : pixel written
// - i_rd_en    : read strobe; o_rd_data updates only when set
// - i_rd_bank  : bank read
// - i_rd_addr  : entry index inside the bank
// - o_rd_data  : registered read data, held while i_rd_en is low
module sampler_frame_buf
  import video_sampler_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic          i_wr_bank,
  input  logic [AW-1:0] i_wr_addr,
  input  rgb888_t       i_wr_data,
  input  logic          i_rd_en,
  input  logic          i_rd_bank,
  input  logic [AW-1:0] i_rd_addr,
  output rgb888_t       o_rd_data
);

  rgb888_t r_mem [0:(2**(AW+1))-1];
  rgb888_t r_rd_data;

  // Holding the read register while i_rd_en is low is what keeps pix_data
  // stable during downstream back-pressure.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/video_frame_sampler.sv
// Point-samples a MATRIX_W x MATRIX_H grid from a decoded DVI RGB stream,
// double-buffers one complete matrix frame and streams it out over
// valid/ready towards the SPI matrix transmitter.
// Ports:
// - clk, rst_n          : pixel clock, asynchronous active-low reset
// - vid_vs/de/r/g/b     : video input (vs polarity set by VS_POL)
// - pix_valid/ready     : output handshake
// - pix_data            : {r,g,b} of the current output pixel
// - pix_sof / pix_eof   : first / last pixel of a matrix frame
// - frame_drop          : pulse, complete frame discarded (output busy)
// - frame_err           : pulse, frame ended with fewer than W*H samples
// Build option: define SAMPLER_SERPENTINE_EN to emit odd rows right-to-left
// (zig-zag LED wiring); otherwise every row is emitted left-to-right.
module video_frame_sampler
  import video_sampler_pkg::*;
#(
  parameter int MATRIX_W = MATRIX_W_DEF,
  parameter int MATRIX_H = MATRIX_H_DEF,
  parameter int H_OFFSET = 0,
  parameter int H_STEP   = 80,
  parameter int V_OFFSET = 0,
  parameter int V_STEP   = 90,
  parameter int VS_POL   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_vs,
  input  logic        vid_de,
  input  logic [7:0]  vid_r,
  input  logic [7:0]  vid_g,
  input  logic [7:0]  vid_b,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eof,
  output logic        frame_drop,
  output logic        frame_err
);

  localparam int N  = MATRIX_W * MATRIX_H;
  localparam int AW = addr_w(N);
  localparam int CW = $clog2(MATRIX_W + 1);
  localparam int RW = $clog2(MATRIX_H + 1);
  localparam int SW = $clog2(N + 1);
  localparam int PW = 16;

  // ---- stage p0: registered video inputs, p1: previous value for edges
  logic    r_vs_act_p0, r_vs_act_p1;
  logic    r_de_p0, r_de_p1;
  rgb888_t r_rgb_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_act_p0 <= 1'b0;
      r_vs_act_p1 <= 1'b0;
      r_de_p0     <= 1'b0;
      r_de_p1     <= 1'b0;
    end else begin
      r_vs_act_p0 <= (VS_POL != 0) ? vid_vs : ~vid_vs;
      r_vs_act_p1 <= r_vs_act_p0;
      r_de_p0     <= vid_de;
      r_de_p1     <= r_de_p0;
    end
  end

  always_ff @(posedge clk) begin
    r_rgb_p0 <= '{r: vid_r, g: vid_g, b: vid_b};
  end

  logic w_vs_edge, w_de_fall;
  assign w_vs_edge = r_vs_act_p0 & ~r_vs_act_p1;
  assign w_de_fall = ~r_de_p0 & r_de_p1;

  // ---- sampling counters, evaluated on p0 data
  logic [PW-1:0] r_x, r_y, r_next_x, r_next_y;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_row_base;
  logic [SW-1:0] r_sample_cnt;
  logic          r_line_hit;
  logic          r_seen_vs;
  logic          r_frame_drop, r_frame_err;

  out_state_t r_state, w_state_nxt;

  logic w_hit, w_complete, w_start;
  assign w_hit = r_de_p0 & ~w_vs_edge & (r_y == r_next_y) & (r_x == r_next_x)
               & (r_col < CW'(MATRIX_W)) & (r_row < RW'(MATRIX_H));
  assign w_complete = (r_sample_cnt == SW'(N));
  assign w_start    = w_vs_edge & r_seen_vs & w_complete & (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_next_x     <= PW'(H_OFFSET);
      r_next_y     <= PW'(V_OFFSET);
      r_col        <= '0;
      r_row        <= '0;
      r_row_base   <= '0;
      r_sample_cnt <= '0;
      r_line_hit   <= 1'b0;
      r_seen_vs    <= 1'b0;
      r_frame_drop <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      // Only the first vs after reset is exempt from completeness checks.
      r_frame_drop <= w_vs_edge & r_seen_vs & w_complete & (r_state != IDLE);
      r_frame_err  <= w_vs_edge & r_seen_vs & ~w_complete;
      if (w_vs_edge) begin
        r_seen_vs    <= 1'b1;
        r_x          <= '0;
        r_y          <= '0;
        r_next_x     <= PW'(H_OFFSET);
        r_next_y     <= PW'(V_OFFSET);
        r_col        <= '0;
        r_row        <= '0;
        r_row_base   <= '0;
        r_sample_cnt <= '0;
        r_line_hit   <= 1'b0;
      end else begin
        // x is held at 0 while de is low, so the first active pixel is x=0.
        r_x <= r_de_p0 ? r_x + 1'b1 : '0;
        if (w_hit) begin
          r_col        <= r_col + 1'b1;
          r_next_x     <= r_next_x + PW'(H_STEP);
          r_sample_cnt <= r_sample_cnt + 1'b1;
          r_line_hit   <= 1'b1;
        end
        if (w_de_fall) begin
          r_y        <= r_y + 1'b1;
          r_next_x   <= PW'(H_OFFSET);
          r_line_hit <= 1'b0;
          if (r_line_hit) begin
            r_row      <= r_row + 1'b1;
            r_col      <= '0;
            r_row_base <= r_row_base + AW'(MATRIX_W);
            r_next_y   <= r_next_y + PW'(V_STEP);
          end
        end
      end
    end
  end

  // ---- output side: front-bank read pointer and index
  logic          r_front;
  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_rd_col;
  logic [AW-1:0] r_rd_base;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_en, w_last;
  rgb888_t       w_rd_data;

  assign w_last = (r_idx == AW'(N - 1));

`ifdef SAMPLER_SERPENTINE_EN
  logic r_rd_odd;
  assign w_rd_addr = r_rd_odd ? (r_rd_base + AW'(MATRIX_W - 1) - AW'(r_rd_col))
                              : (r_rd_base + AW'(r_rd_col));
`else
  assign w_rd_addr = r_rd_base + AW'(r_rd_col);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A read is issued on FETCH and on every accepted non-final pixel, so the
  // RAM register always holds the pixel being presented.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE:   if (w_start) w_state_nxt = FETCH;
      FETCH: begin
        w_rd_en     = 1'b1;
        w_state_nxt = STREAM;
      end
      STREAM: if (pix_ready) begin
        if (w_last) w_state_nxt = IDLE;
        else        w_rd_en     = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front   <= 1'b0;
      r_idx     <= '0;
      r_rd_col  <= '0;
      r_rd_base <= '0;
`ifdef SAMPLER_SERPENTINE_EN
      r_rd_odd  <= 1'b0;
`endif
    end else begin
      if (w_start) r_front <= ~r_front;
      if (r_state == IDLE) begin
        r_idx     <= '0;
        r_rd_col  <= '0;
        r_rd_base <= '0;
`ifdef SAMPLER_SERPENTINE_EN
        r_rd_odd  <= 1'b0;
`endif
      end else begin
        if ((r_state == STREAM) && pix_ready && !w_last) r_idx <= r_idx + 1'b1;
        if (w_rd_en) begin
          if (r_rd_col == CW'(MATRIX_W - 1)) begin
            r_rd_col  <= '0;
            r_rd_base <= r_rd_base + AW'(MATRIX_W);
`ifdef SAMPLER_SERPENTINE_EN
            r_rd_odd  <= ~r_rd_odd;
`endif
          end else begin
            r_rd_col <= r_rd_col + 1'b1;
          end
        end
      end
    end
  end

  sampler_frame_buf #(.AW(AW)) u_buf (
    .clk       (clk),
    .i_wr_en   (w_hit),
    .i_wr_bank (~r_front),
    .i_wr_addr (r_row_base + AW'(r_col)),
    .i_wr_data (r_rgb_p0),
    .i_rd_en   (w_rd_en),
    .i_rd_bank (r_front),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign pix_valid  = (r_state == STREAM);
  assign pix_data   = pix_valid ? w_rd_data : 24'h0;
  assign pix_sof    = pix_valid & (r_idx == '0);
  assign pix_eof    = pix_valid & w_last;
  assign frame_drop = r_frame_drop;
  assign frame_err  = r_frame_err;

endmodule
